// File: rtl/modulo_buffer_principal_rolhas.sv
// Main cork buffer: counts corks, consumes one per consumo edge, refills in batches from the secondary buffer.
// Refill handshake: registered xfer_req held until xfer_ack, then one registered xfer_dec strobe per cork moved.
module modulo_buffer_principal_rolhas #(
   parameter int MIN_ROLHAS = 5,
   parameter int LOTE       = 15,
   parameter int CAPACIDADE = 99
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       enable,
   input  logic       consumo,
   input  logic [6:0] sec_count,
   input  logic       xfer_ack,
   output logic [6:0] reg_r,
   output logic       min_signal,
   output logic       ro,
   output logic       xfer_req,
   output logic       xfer_dec,
   output logic       busy,
   output logic       falta
);

   localparam logic [6:0] MIN_W  = 7'(MIN_ROLHAS);
   localparam logic [6:0] LOTE_W = 7'(LOTE);
   localparam logic [6:0] CAP_W  = 7'(CAPACIDADE);

   typedef enum logic [1:0] {OCIOSO, SOLICITA, TRANSFERE, FIM} estado_t;

   estado_t    estado_q, estado_d;
   logic [6:0] reg_q, reg_d;
   logic [6:0] qtd_q, qtd_d;
   logic       cons_q;
   logic       falta_q, falta_d;
   logic       req_q, req_d;
   logic       dec_q, dec_d;
   logic       borda;
   logic       inc;
   logic [6:0] espaco;
   logic [6:0] lim;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         estado_q <= OCIOSO;
         reg_q    <= '0;
         qtd_q    <= '0;
         cons_q   <= 1'b0;
         falta_q  <= 1'b0;
         req_q    <= 1'b0;
         dec_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         reg_q    <= reg_d;
         qtd_q    <= qtd_d;
         cons_q   <= consumo;
         falta_q  <= falta_d;
         req_q    <= req_d;
         dec_q    <= dec_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      qtd_d    = qtd_q;
      req_d    = 1'b0;
      dec_d    = 1'b0;
      inc      = 1'b0;
      borda    = consumo & ~cons_q;
      espaco   = (reg_q >= CAP_W) ? 7'd0 : CAP_W - reg_q;
      lim      = LOTE_W;
      if (sec_count < lim) lim = sec_count;
      if (espaco < lim)    lim = espaco;

      case (estado_q)
         OCIOSO: begin
            if (enable && min_signal && (sec_count != 7'd0)) begin
               estado_d = SOLICITA;
               qtd_d    = lim;
            end
         end
         SOLICITA: begin
            // Ack only counts once our own request is actually visible outside.
            if (xfer_ack && req_q) estado_d = TRANSFERE;
            else                   req_d    = 1'b1;
         end
         TRANSFERE: begin
            if ((sec_count != 7'd0) && (qtd_q != 7'd0)) begin
               inc   = 1'b1;
               dec_d = 1'b1;
               qtd_d = qtd_q - 7'd1;
               if (qtd_q == 7'd1) estado_d = FIM;
            end else begin
               estado_d = FIM;
            end
         end
         default: estado_d = OCIOSO;
      endcase

      reg_d = reg_q;
      if (inc && !borda)      reg_d = (reg_q >= CAP_W) ? CAP_W : reg_q + 7'd1;
      else if (borda && !inc) reg_d = (reg_q == 7'd0) ? 7'd0 : reg_q - 7'd1;
      falta_d = falta_q | (borda & (reg_q == 7'd0));
   end

   assign reg_r      = reg_q;
   assign min_signal = (reg_q < MIN_W);
   assign ro         = (reg_q == 7'd0);
   assign xfer_req   = req_q;
   assign xfer_dec   = dec_q;
   assign busy       = (estado_q != OCIOSO);
   assign falta      = falta_q;

endmodule

// File: tb/tb_modulo_buffer_principal_rolhas.sv
// Bench for modulo_buffer_principal_rolhas: directed refill scenarios plus random traffic against a cork-count model.
module tb_modulo_buffer_principal_rolhas;
   localparam int MINR = 5;
   localparam int LOTE = 15;
   localparam int CAP  = 99;

   logic       clk = 1'b0;
   logic       clr;
   logic       enable;
   logic       consumo;
   logic [6:0] sec_count;
   logic       xfer_ack;
   logic [6:0] reg_r;
   logic       min_signal, ro, xfer_req, xfer_dec, busy, falta;

   modulo_buffer_principal_rolhas #(.MIN_ROLHAS(MINR), .LOTE(LOTE), .CAPACIDADE(CAP)) dut (
      .clk(clk), .clr(clr), .enable(enable), .consumo(consumo), .sec_count(sec_count),
      .xfer_ack(xfer_ack), .reg_r(reg_r), .min_signal(min_signal), .ro(ro),
      .xfer_req(xfer_req), .xfer_dec(xfer_dec), .busy(busy), .falta(falta)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: corks in stock, refill phase (0 idle, 1 asking, 2 moving, 3 gap), corks still owed.
   int m_lvl, m_phase, m_left, m_req, m_dec, m_falta, m_prev;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lvl = 0; m_phase = 0; m_left = 0; m_req = 0; m_dec = 0; m_falta = 0; m_prev = 0;
   endtask

   function automatic int min3(input int a, input int b, input int c);
      int r;
      r = a;
      if (b < r) r = b;
      if (c < r) r = c;
      return r;
   endfunction

   task automatic model_step();
      int e;
      int got_one;
      e = (consumo && m_prev == 0) ? 1 : 0;
      got_one = 0;
      if (e == 1 && m_lvl == 0) m_falta = 1;
      case (m_phase)
         0: begin
            m_req = 0; m_dec = 0;
            if (enable && m_lvl < MINR && sec_count != 0) begin
               m_left  = min3(LOTE, int'(sec_count), CAP - m_lvl);
               m_phase = 1;
            end
         end
         1: begin
            m_dec = 0;
            if (xfer_ack && m_req == 1) begin m_req = 0; m_phase = 2; end
            else m_req = 1;
         end
         2: begin
            m_req = 0;
            if (sec_count != 0 && m_left > 0) begin
               got_one = 1; m_dec = 1; m_left--;
               if (m_left == 0) m_phase = 3;
            end else begin
               m_dec = 0; m_phase = 3;
            end
         end
         default: begin m_req = 0; m_dec = 0; m_phase = 0; end
      endcase
      m_lvl = m_lvl + got_one - e;
      if (m_lvl < 0)   m_lvl = 0;
      if (m_lvl > CAP) m_lvl = CAP;
      m_prev = consumo ? 1 : 0;
   endtask

   task automatic compare_all();
      check("reg_r",      int'(reg_r),      m_lvl);
      check("min_signal", int'(min_signal), (m_lvl < MINR) ? 1 : 0);
      check("ro",         int'(ro),         (m_lvl == 0) ? 1 : 0);
      check("xfer_req",   int'(xfer_req),   m_req);
      check("xfer_dec",   int'(xfer_dec),   m_dec);
      check("busy",       int'(busy),       (m_phase != 0) ? 1 : 0);
      check("falta",      int'(falta),      m_falta);
   endtask

   int strobes;

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (xfer_dec) strobes++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulses(input int n);
      for (int k = 0; k < n; k++) begin
         consumo = 1'b1; tick();
         consumo = 1'b0; tick();
      end
   endtask

   bit clr_done;

   initial begin
      clr = 1'b1; enable = 1'b0; consumo = 1'b0; sec_count = 7'd0; xfer_ack = 1'b0;
      model_reset();
      #12;
      compare_all();
      check("reset_ro",  int'(ro), 1);
      check("reset_min", int'(min_signal), 1);

      // First refill from a full secondary with ack tied high.
      enable = 1'b1; sec_count = 7'd40; xfer_ack = 1'b1; clr = 1'b0;
      strobes = 0;
      tick();
      check("req_after_edge1", int'(xfer_req), 0);
      tick();
      check("req_after_edge2", int'(xfer_req), 1);
      ticks(25);
      check("first_strobes", strobes, 15);
      check("first_level", int'(reg_r), 15);
      check("first_min", int'(min_signal), 0);
      check("first_ro", int'(ro), 0);

      // Drain 12 corks; refill kicks in below the minimum.
      strobes = 0;
      pulses(12);
      ticks(30);
      check("second_strobes", strobes, 15);
      check("second_level", int'(reg_r), 18);

      // Empty with refills blocked, then consume past zero.
      enable = 1'b0;
      pulses(20);
      check("empty_level", int'(reg_r), 0);
      check("falta_set", int'(falta), 1);

      // Secondary only holds 6.
      enable = 1'b1; sec_count = 7'd6; strobes = 0;
      ticks(20);
      check("short_strobes", strobes, 6);
      check("short_level", int'(reg_r), 6);

      // Random traffic with one asynchronous clear, preferably mid-transfer.
      clr_done = 0;
      for (int i = 0; i < 3000; i++) begin
         consumo  = ($urandom_range(0, 2) == 0);
         xfer_ack = ($urandom_range(0, 1) == 1);
         enable   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0)
            sec_count = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 40));
         if (!clr_done && i >= 1500 && (m_phase == 2 || i == 2500)) begin
            clr_done = 1;
            clr = 1'b1;
            #1;
            model_reset();
            check("clr_level", int'(reg_r), 0);
            check("clr_dec", int'(xfer_dec), 0);
            check("clr_busy", int'(busy), 0);
            clr = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
